// File: rtl/rtype_pkg.sv
// rtype_pkg: shared encodings for the pipelined R-type execute unit.
// Holds the opcode, funct3 and funct7 constants, the ALU operation enum and
// the decoded-instruction record that stage S1 carries.
package rtype_pkg;

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_OP32 = 7'b0111011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic       illegal;
        alu_op_e    op;
        logic       w_mode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_t;

endpackage

// File: rtl/rtype_alu.sv
// rtype_alu: combinational ALU for the R-type execute unit.
// Ports:
//   a, b    in  XLEN  operands
//   op      in        operation (alu_op_e)
//   w_mode  in  1     compute on the low 32 bits and sign-extend the result
//   y       out XLEN  result
module rtype_alu
    import rtype_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    input  logic            w_mode,
    output logic [XLEN-1:0] y
);

    localparam int SH_W = (XLEN == 64) ? 6 : 5;

    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] y_full;
    logic [XLEN-1:0] y_w;
    logic [31:0]     a32;
    logic [31:0]     b32;
    logic [31:0]     y32;

    always_comb begin
        shamt  = b[SH_W-1:0];
        y_full = '0;
        unique case (op)
            ALU_ADD:  y_full = a + b;
            ALU_SUB:  y_full = a - b;
            ALU_SLL:  y_full = a << shamt;
            ALU_SLT:  y_full = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: y_full = XLEN'(a < b);
            ALU_XOR:  y_full = a ^ b;
            ALU_SRL:  y_full = a >> shamt;
            ALU_SRA:  y_full = XLEN'($signed(a) >>> shamt);
            ALU_OR:   y_full = a | b;
            ALU_AND:  y_full = a & b;
            default:  y_full = '0;
        endcase
    end

    // Word ops only ever use the low 32 bits and a 5-bit shift amount.
    always_comb begin
        a32 = a[31:0];
        b32 = b[31:0];
        y32 = '0;
        case (op)
            ALU_ADD: y32 = a32 + b32;
            ALU_SUB: y32 = a32 - b32;
            ALU_SLL: y32 = a32 << b32[4:0];
            ALU_SRL: y32 = a32 >> b32[4:0];
            ALU_SRA: y32 = 32'($signed(a32) >>> b32[4:0]);
            default: y32 = '0;
        endcase
        y_w       = {XLEN{y32[31]}};
        y_w[31:0] = y32;
        y         = w_mode ? y_w : y_full;
    end

endmodule

// File: rtl/rtype_pipe.sv
// rtype_pipe: two-stage R-type execute unit with internal register file,
// write-back bypass and valid/ready flow control on issue and write-back.
// S1 holds the decoded instruction and reads operands; S2 is the wb_* register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   instr_valid/instr/instr_ready   issue handshake, raw 32-bit instruction
//   wb_valid/wb_ready               write-back handshake; retire on both high
//   wb_rd, wb_data, wb_illegal      presented result
//   dbg_raddr/dbg_rdata             unbypassed register-file read
//   retire_cnt                      legal retirements, wraps at 2^32
module rtype_pipe
    import rtype_pkg::*;
#(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    localparam int RA_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_illegal,
    input  logic [RA_W-1:0] dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    output logic [31:0]     retire_cnt
);

    logic [XLEN-1:0] rf [NREG];

    dec_t            s1_q;
    logic            s1_valid;
    logic            s1_advance;
    logic            accept;
    logic            retire;
    logic            fwd_ok;
    logic [XLEN-1:0] rs1_rf;
    logic [XLEN-1:0] rs2_rf;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_y;

    function automatic logic out_of_range(input logic [4:0] r);
        return (32'(r) >> RA_W) != 32'd0;
    endfunction

    function automatic dec_t decode(input logic [31:0] w);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3        = w[14:12];
        f7        = w[31:25];
        d.rd      = w[11:7];
        d.rs1     = w[19:15];
        d.rs2     = w[24:20];
        d.op      = ALU_ADD;
        d.w_mode  = 1'b0;
        d.illegal = 1'b1;
        if (w[6:0] == OPC_OP) begin
            if (f7 == F7_BASE) begin
                d.illegal = 1'b0;
                case (f3)
                    F3_ADD:  d.op = ALU_ADD;
                    F3_SLL:  d.op = ALU_SLL;
                    F3_SLT:  d.op = ALU_SLT;
                    F3_SLTU: d.op = ALU_SLTU;
                    F3_XOR:  d.op = ALU_XOR;
                    F3_SR:   d.op = ALU_SRL;
                    F3_OR:   d.op = ALU_OR;
                    default: d.op = ALU_AND;
                endcase
            end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                d.illegal = 1'b0;
                d.op      = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == F3_SR) begin
                d.illegal = 1'b0;
                d.op      = ALU_SRA;
            end
        end else if (XLEN == 64 && w[6:0] == OPC_OP32) begin
            d.w_mode = 1'b1;
            if (f7 == F7_BASE) begin
                case (f3)
                    F3_ADD:  begin d.illegal = 1'b0; d.op = ALU_ADD; end
                    F3_SLL:  begin d.illegal = 1'b0; d.op = ALU_SLL; end
                    F3_SR:   begin d.illegal = 1'b0; d.op = ALU_SRL; end
                    default: d.illegal = 1'b1;
                endcase
            end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                d.illegal = 1'b0;
                d.op      = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == F3_SR) begin
                d.illegal = 1'b0;
                d.op      = ALU_SRA;
            end
        end
        if (out_of_range(d.rd) || out_of_range(d.rs1) || out_of_range(d.rs2)) begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    assign retire      = wb_valid & wb_ready;
    assign s1_advance  = s1_valid & (~wb_valid | wb_ready);
    assign instr_ready = ~s1_valid | s1_advance;
    assign accept      = instr_valid & instr_ready;

    // Only S2 can hold a result not yet in the register file, so it is the
    // single bypass source. rf[0] is never written and so reads as zero.
    always_comb begin
        fwd_ok = wb_valid & ~wb_illegal & (wb_rd != 5'd0);
        rs1_rf = out_of_range(s1_q.rs1) ? '0 : rf[s1_q.rs1[RA_W-1:0]];
        rs2_rf = out_of_range(s1_q.rs2) ? '0 : rf[s1_q.rs2[RA_W-1:0]];
        op_a   = (fwd_ok && wb_rd == s1_q.rs1) ? wb_data : rs1_rf;
        op_b   = (fwd_ok && wb_rd == s1_q.rs2) ? wb_data : rs2_rf;
    end

    rtype_alu #(.XLEN(XLEN)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (s1_q.op),
        .w_mode (s1_q.w_mode),
        .y      (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_q       <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_illegal <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (accept) begin
                s1_q     <= decode(instr);
                s1_valid <= 1'b1;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
            if (s1_advance) begin
                wb_valid   <= 1'b1;
                wb_rd      <= s1_q.rd;
                wb_data    <= s1_q.illegal ? '0 : alu_y;
                wb_illegal <= s1_q.illegal;
            end else if (retire) begin
                wb_valid <= 1'b0;
            end
            if (retire && !wb_illegal) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (retire && !wb_illegal && wb_rd != 5'd0) begin
            rf[wb_rd[RA_W-1:0]] <= wb_data;
        end
    end

    assign dbg_rdata = rf[dbg_raddr];

endmodule

// File: tb/tb_rtype_pipe.sv
// tb_rtype_pipe: self-checking bench for rtype_pipe (XLEN=64, NREG=32).
// An ISA-level model executes each accepted instruction in program order;
// results queue up and are matched against wb_* at retirement. Since the
// datapath can only create nonzero values from nonzero registers, seed values
// are injected by overriding the ALU result while a seeding ADD is in S1.
`timescale 1ns/1ps
module tb_rtype_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_illegal;
    logic [4:0]  dbg_raddr;
    logic [63:0] dbg_rdata;
    logic [31:0] retire_cnt;

    rtype_pipe #(.XLEN(64), .NREG(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_illegal  (wb_illegal),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rd;
        logic [63:0] data;
        bit          ill;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [63:0] arch [32];
    logic [63:0] comm [32];
    logic [31:0] exp_cnt;
    int          cyc;
    int          n_vec;
    int          n_err;
    bit          last_acc;
    bit          pre_on;
    logic [63:0] pre_val;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd, input logic [6:0] opc);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), opc};
    endfunction

    // ISA reference: returns 1 for a supported encoding.
    function automatic bit ref_exec(input logic [31:0] w, output logic [63:0] res);
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] r32;
        a   = arch[w[19:15]];
        b   = arch[w[24:20]];
        res = '0;
        r32 = '0;
        if (w[6:0] == 7'h33) begin
            case ({w[31:25], w[14:12]})
                {7'h00, 3'd0}: res = a + b;
                {7'h20, 3'd0}: res = a - b;
                {7'h00, 3'd1}: res = a << b[5:0];
                {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                {7'h00, 3'd3}: res = (a < b) ? 64'd1 : 64'd0;
                {7'h00, 3'd4}: res = a ^ b;
                {7'h00, 3'd5}: res = a >> b[5:0];
                {7'h20, 3'd5}: res = $signed(a) >>> b[5:0];
                {7'h00, 3'd6}: res = a | b;
                {7'h00, 3'd7}: res = a & b;
                default: return 1'b0;
            endcase
            return 1'b1;
        end
        if (w[6:0] == 7'h3b) begin
            case ({w[31:25], w[14:12]})
                {7'h00, 3'd0}: r32 = a[31:0] + b[31:0];
                {7'h20, 3'd0}: r32 = a[31:0] - b[31:0];
                {7'h00, 3'd1}: r32 = a[31:0] << b[4:0];
                {7'h00, 3'd5}: r32 = a[31:0] >> b[4:0];
                {7'h20, 3'd5}: r32 = $signed(a[31:0]) >>> b[4:0];
                default: return 1'b0;
            endcase
            res = {{32{r32[31]}}, r32};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: drive at the falling edge, check 1 ns later, book-keep the
    // handshakes that the next rising edge will complete.
    task automatic cycle(input logic v, input logic [31:0] w, input logic rdy);
        exp_t        e;
        logic [63:0] res;
        bit          legal;
        bit          exp_wbv;
        @(negedge clk);
        instr_valid = v;
        instr       = w;
        wb_ready    = rdy;
        #1;
        exp_wbv = (q.size() != 0) && (q[0].acc + 2 <= cyc);
        chk("wb_valid", 64'(wb_valid), 64'(exp_wbv));
        if (exp_wbv) begin
            chk("wb_rd", 64'(wb_rd), 64'(q[0].rd));
            chk("wb_illegal", 64'(wb_illegal), 64'(q[0].ill));
            if (!q[0].ill) chk("wb_data", wb_data, q[0].data);
        end
        chk("instr_ready", 64'(instr_ready), 64'((q.size() < 2) || rdy));
        chk("retire_cnt", 64'(retire_cnt), 64'(exp_cnt));
        if (exp_wbv && rdy) begin
            if (!q[0].ill) begin
                exp_cnt++;
                if (q[0].rd != 0) comm[q[0].rd] = q[0].data;
            end
            void'(q.pop_front());
        end
        last_acc = v && instr_ready;
        if (last_acc) begin
            legal = ref_exec(w, res);
            if (pre_on) begin
                legal = 1'b1;
                res   = pre_val;
            end
            e.rd   = int'(w[11:7]);
            e.data = res;
            e.ill  = !legal;
            e.acc  = cyc;
            if (legal && e.rd != 0) arch[e.rd] = res;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && q.size() != 0; k++) cycle(1'b0, 32'h0, 1'b1);
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
        cycle(1'b0, 32'h0, 1'b1);
    endtask

    task automatic issue(input logic [31:0] w);
        for (int k = 0; k < 30; k++) begin
            cycle(1'b1, w, 1'b1);
            if (last_acc) return;
        end
        chk("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic preload(input int r, input logic [63:0] v);
        drain();
        pre_val = v;
        pre_on  = 1'b1;
        force dut.alu_y = pre_val;
        issue(enc(7'h00, 0, 0, 3'd0, r, 7'h33));
        pre_on = 1'b0;
        drain();
        release dut.alu_y;
    endtask

    task automatic dbg_read(input int r, output logic [63:0] v);
        instr_valid = 1'b0;
        dbg_raddr   = 5'(r);
        #1;
        v = dbg_rdata;
    endtask

    task automatic dbg_sweep();
        logic [63:0] v;
        for (int i = 0; i < 32; i++) begin
            dbg_read(i, v);
            chk($sformatf("dbg_x%0d", i), v, comm[i]);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int          s;
        logic [6:0]  opc;
        logic [6:0]  f7;
        s   = int'($urandom_range(0, 9));
        opc = (s < 6) ? 7'h33 : (s < 9) ? 7'h3b : 7'($urandom);
        s   = int'($urandom_range(0, 9));
        f7  = (s < 6) ? 7'h00 : (s < 9) ? 7'h20 : 7'h01;
        return enc(f7, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   3'($urandom), int'($urandom_range(0, 15)), opc);
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) begin
            arch[i] = '0;
            comm[i] = '0;
        end
        exp_cnt = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        logic [31:0] cur;
        int          acc_bp;
        logic [31:0] bp_w [3];

        cyc = 0; n_vec = 0; n_err = 0; pre_on = 1'b0; pre_val = '0;
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; wb_ready = 1'b1; dbg_raddr = '0;
        model_reset();
        #1;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_instr_ready", 64'(instr_ready), 64'd1);
        chk("rst_retire_cnt", 64'(retire_cnt), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        dbg_sweep();

        // Basic arithmetic and compares.
        preload(1, 64'd5);
        preload(2, 64'd3);
        cycle(1'b1, enc(7'h00, 2, 1, 3'd0, 3, 7'h33), 1'b1);
        chk("add_acc", 64'(last_acc), 64'd1);
        cycle(1'b1, enc(7'h20, 2, 1, 3'd0, 4, 7'h33), 1'b1);
        chk("sub_acc", 64'(last_acc), 64'd1);
        issue(enc(7'h00, 1, 2, 3'd2, 5, 7'h33));
        // Dependent chain at one per cycle, fed through the bypass.
        cycle(1'b1, enc(7'h00, 1, 1, 3'd0, 6, 7'h33), 1'b1);
        chk("chain0_acc", 64'(last_acc), 64'd1);
        cycle(1'b1, enc(7'h00, 6, 6, 3'd0, 7, 7'h33), 1'b1);
        chk("chain1_acc", 64'(last_acc), 64'd1);
        cycle(1'b1, enc(7'h00, 6, 7, 3'd0, 8, 7'h33), 1'b1);
        chk("chain2_acc", 64'(last_acc), 64'd1);
        drain();
        dbg_read(3, v); chk("x3_add", v, 64'd8);
        dbg_read(4, v); chk("x4_sub", v, 64'd2);
        dbg_read(5, v); chk("x5_slt", v, 64'd1);
        dbg_read(6, v); chk("x6_chain", v, 64'd10);
        dbg_read(7, v); chk("x7_chain", v, 64'd20);
        dbg_read(8, v); chk("x8_chain", v, 64'd30);

        preload(1, 64'hFFFF_FFFF_FFFF_FFFF);
        preload(10, 64'd1);
        issue(enc(7'h00, 2, 1, 3'd3, 10, 7'h33));
        preload(1, 64'h0000_0000_7FFF_FFFF);
        preload(2, 64'd1);
        issue(enc(7'h00, 2, 1, 3'd0, 9, 7'h3b));
        preload(11, 64'h8000_0000_0000_0000);
        preload(12, 64'd63);
        issue(enc(7'h20, 12, 11, 3'd5, 13, 7'h33));
        issue(32'h0220_8033);
        issue(enc(7'h00, 2, 1, 3'd0, 0, 7'h33));
        drain();
        dbg_read(10, v); chk("x10_sltu", v, 64'd0);
        dbg_read(9, v);  chk("x9_addw", v, 64'hFFFF_FFFF_8000_0000);
        dbg_read(13, v); chk("x13_sra", v, 64'hFFFF_FFFF_FFFF_FFFF);
        dbg_read(0, v);  chk("x0_zero", v, 64'd0);
        dbg_sweep();

        // Backpressure: three issues against a stalled consumer.
        bp_w[0] = enc(7'h00, 2, 1, 3'd4, 14, 7'h33);
        bp_w[1] = enc(7'h00, 14, 1, 3'd6, 15, 7'h33);
        bp_w[2] = enc(7'h00, 15, 14, 3'd7, 14, 7'h33);
        acc_bp = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, bp_w[acc_bp], 1'b0);
            if (last_acc) acc_bp++;
        end
        chk("bp_accepted", 64'(acc_bp), 64'd2);
        for (int k = 0; k < 20 && acc_bp < 3; k++) begin
            cycle(1'b1, bp_w[acc_bp], 1'b1);
            if (last_acc) acc_bp++;
        end
        chk("bp_all_issued", 64'(acc_bp), 64'd3);
        drain();
        dbg_sweep();

        // Randomized traffic over seeded registers.
        for (int r = 1; r < 16; r++) preload(r, {$urandom, $urandom});
        preload(3, 64'h8000_0000_0000_0000);
        preload(4, 64'hFFFF_FFFF_FFFF_FFFF);
        cur = rand_instr();
        for (int k = 0; k < 500; k++) begin
            cycle($urandom_range(0, 9) < 8, cur, $urandom_range(0, 9) < 7);
            if (last_acc) cur = rand_instr();
        end
        drain();
        dbg_sweep();

        // Asynchronous reset with instructions in flight.
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, cur, k < 8);
            if (last_acc) cur = rand_instr();
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("mid_rst_instr_ready", 64'(instr_ready), 64'd1);
        chk("mid_rst_retire_cnt", 64'(retire_cnt), 64'd0);
        chk("mid_rst_wb_data", wb_data, 64'd0);
        model_reset();
        instr_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        dbg_sweep();

        preload(1, 64'd7);
        for (int k = 0; k < 40; k++) begin
            cycle($urandom_range(0, 9) < 8, cur, $urandom_range(0, 9) < 7);
            if (last_acc) cur = rand_instr();
        end
        drain();
        dbg_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
